dir_scheduler: RTL and testbench
================================

DIR_SCHEDULER -- requirements
Module: dir_scheduler

Interface
REQ-001 Parameter P1_INIT, default 4'b0001, P1 heading loaded in IDLE (RIGHT).
REQ-002 Parameter P2_INIT, default 4'b0010, P2 heading loaded in IDLE (LEFT).
REQ-003 Parameter QDEPTH, default 2, turn-queue entries per player (legal range 1..4).
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous and active-low.
REQ-006 i_p1_dir  in  4  P1 key levels {UP,DOWN,LEFT,RIGHT} from the PS/2 key decoder; one-hot or zero.
REQ-007 i_p2_dir  in  4  P2 key levels, same encoding.
REQ-008 i_tick  in  1  one-cycle game-step pulse.
REQ-009 i_start  in  1  one-cycle pulse; IDLE -> RUN.
REQ-010 i_pause  in  1  one-cycle pulse; toggles RUN <-> PAUSE.
REQ-011 i_game_over  in  1  one-cycle pulse; any state -> IDLE.
REQ-012 o_p1_head  out  4  committed P1 heading, one-hot.
REQ-013 o_p2_head  out  4  committed P2 heading, one-hot.
REQ-014 o_p1_turn  out  1  one-cycle pulse when P1 heading changes on a tick.
REQ-015 o_p2_turn  out  1  one-cycle pulse when P2 heading changes on a tick.
REQ-016 o_state  out  2  00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-017 Each player SHALL own an independent FIFO of QDEPTH 4-bit directions, with an occupancy count 0..QDEPTH.
REQ-018 Press event: a cycle where i_pN_dir is nonzero and differs from its registered value of the previous cycle; releases (to zero) and held keys SHALL NOT generate events.
REQ-019 A non-one-hot nonzero i_pN_dir SHALL be ignored (no event; registered value still updated).
REQ-020 Reference direction = queue tail if occupancy > 0, else committed head.
REQ-021 Press SHALL be enqueued only in RUN, only if it is neither equal to nor the reverse of the reference (UP/DOWN, LEFT/RIGHT), and only if not full after any same-cycle pop.
REQ-022 Press rejected by REQ-021 SHALL be discarded silently; queue unchanged.
REQ-023 On i_tick in RUN with occupancy > 0: pop front into head, assert o_pN_turn next cycle for exactly one cycle, occupancy decrements.
REQ-024 On i_tick in RUN with occupancy 0: head unchanged, no turn pulse.
REQ-025 Simultaneous tick pop and accepted press: both happen; occupancy unchanged; full queue with pop SHALL accept the press.
REQ-026 Head update visible one cycle after the tick (registered output).
REQ-027 FSM: IDLE --i_start--> RUN; RUN --i_pause--> PAUSE; PAUSE --i_pause--> RUN; any --i_game_over--> IDLE.
REQ-028 i_game_over SHALL take priority over i_start, i_pause and i_tick in the same cycle.
REQ-029 Entering IDLE SHALL load heads with P1_INIT/P2_INIT, flush both queues, clear turn pulses.
REQ-030 In PAUSE: queues and heads retained; i_tick and press events ignored.
REQ-031 In IDLE: i_tick, i_pause, presses ignored; i_start during IDLE with i_tick same cycle SHALL NOT pop.
REQ-032 P1 and P2 paths SHALL be fully independent; simultaneous presses on both both evaluated.

Reset
REQ-033 i_rst_n low at a clock edge: o_state=IDLE, o_p1_head=P1_INIT, o_p2_head=P2_INIT, queues empty, o_pN_turn=0, registered key values=0.
REQ-034 Reset asserted mid-RUN or mid-PAUSE SHALL discard all queued turns with no turn pulse.

Verification
REQ-035 Reset, i_start, P1 press UP, tick -> o_p1_head=1000 one cycle after tick, o_p1_turn high one cycle, o_p2_head=0010.
REQ-036 RUN, P1 head RIGHT, press LEFT then RIGHT, tick -> both rejected, head stays 0001, no turn pulse.
REQ-037 RUN, head RIGHT, press UP, LEFT, DOWN (QDEPTH=2) -> UP,LEFT queued, DOWN dropped; ticks yield 1000 then 0010 then hold.
REQ-038 Queue full (UP,LEFT) and tick coincident with press DOWN -> UP committed, queue becomes LEFT,DOWN.
REQ-039 RUN, queue holds UP, i_pause, tick, press DOWN -> head unchanged, queue unchanged; i_pause, tick -> head 1000.
REQ-040 Queued turns, i_game_over with i_tick same cycle -> o_state=00, heads 0001/0010, no turn pulse, subsequent ticks ignored.

Source files
------------

// File: rtl/dir_scheduler_if.sv
// -----------------------------------------------------------------------------
// dir_scheduler_if
// Bundles the game-control inputs and committed-heading outputs of the
// two-player direction scheduler.
//   i_p1_dir / i_p2_dir : key levels {UP,DOWN,LEFT,RIGHT}, one-hot or zero
//   i_tick              : one-cycle game-step pulse
//   i_start / i_pause   : one-cycle FSM control pulses
//   i_game_over         : one-cycle pulse, returns the scheduler to IDLE
//   o_p1_head/o_p2_head : committed one-hot headings
//   o_p1_turn/o_p2_turn : one-cycle pulse when a heading changes on a tick
//   o_state             : 00 IDLE, 01 RUN, 10 PAUSE
// master drives the inputs (game controller), slave is the scheduler.
// -----------------------------------------------------------------------------
interface dir_scheduler_if;
   logic [3:0] i_p1_dir;
   logic [3:0] i_p2_dir;
   logic       i_tick;
   logic       i_start;
   logic       i_pause;
   logic       i_game_over;
   logic [3:0] o_p1_head;
   logic [3:0] o_p2_head;
   logic       o_p1_turn;
   logic       o_p2_turn;
   logic [1:0] o_state;

   modport master (
      output i_p1_dir, i_p2_dir, i_tick, i_start, i_pause, i_game_over,
      input  o_p1_head, o_p2_head, o_p1_turn, o_p2_turn, o_state
   );

   modport slave (
      input  i_p1_dir, i_p2_dir, i_tick, i_start, i_pause, i_game_over,
      output o_p1_head, o_p2_head, o_p1_turn, o_p2_turn, o_state
   );
endinterface

// File: rtl/dir_scheduler.sv
// -----------------------------------------------------------------------------
// dir_scheduler
// Two-player snake-style direction scheduler. Each player's key presses are
// filtered (edge-detected, one-hot only, no same/reverse of the last intended
// direction) and buffered in a small turn queue; each game tick in RUN commits
// the oldest queued turn to the player's heading.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : dir_scheduler_if.slave (key levels, tick/start/pause/game_over
//             pulses in; headings, turn pulses and FSM state out)
// Parameters: P1_INIT / P2_INIT headings loaded in IDLE, QDEPTH queue entries
// per player (1..4).
// -----------------------------------------------------------------------------
module dir_scheduler #(
   parameter logic [3:0] P1_INIT = 4'b0001,
   parameter logic [3:0] P2_INIT = 4'b0010,
   parameter int         QDEPTH  = 2
) (
   input logic             i_clk,
   input logic             i_rst_n,
   dir_scheduler_if.slave  bus
);

   localparam int CW = $clog2(QDEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    key_q  [2];
   logic [3:0]    key_d  [2];
   logic [3:0]    head_q [2];
   logic [3:0]    head_d [2];
   logic [3:0]    fifo_q [2][QDEPTH];
   logic [3:0]    fifo_d [2][QDEPTH];
   logic [CW-1:0] cnt_q  [2];
   logic [CW-1:0] cnt_d  [2];
   logic          turn_q [2];
   logic          turn_d [2];

   logic [3:0]    dir_in [2];
   logic [3:0]    init_h [2];
   logic          run_act;

   assign dir_in[0] = bus.i_p1_dir;
   assign dir_in[1] = bus.i_p2_dir;
   assign init_h[0] = P1_INIT;
   assign init_h[1] = P2_INIT;

   // Queue/tick activity only in RUN, and game_over overrides everything.
   assign run_act = (state_q == S_RUN) && !bus.i_game_over;

   function automatic logic is_onehot(input logic [3:0] d);
      return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
   endfunction

   // {UP,DOWN,LEFT,RIGHT} -> swap UP/DOWN and LEFT/RIGHT
   function automatic logic [3:0] reverse_dir(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   always_comb begin
      state_d = state_q;
      if (bus.i_game_over) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.i_start) state_d = S_RUN;
            S_RUN:   if (bus.i_pause) state_d = S_PAUSE;
            S_PAUSE: if (bus.i_pause) state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase
      end

      for (int p = 0; p < 2; p++) begin
         logic [3:0]    ref_dir;
         logic          press;
         logic          pop;
         logic          push;
         logic [CW-1:0] wr_idx;

         key_d[p]  = dir_in[p];
         head_d[p] = head_q[p];
         fifo_d[p] = fifo_q[p];
         cnt_d[p]  = cnt_q[p];
         turn_d[p] = 1'b0;

         // New turns are judged against the last intended direction, which is
         // the queue tail when anything is pending.
         ref_dir = head_q[p];
         for (int i = 0; i < QDEPTH; i++) begin
            if (CW'(i + 1) == cnt_q[p]) ref_dir = fifo_q[p][i];
         end

         // Held keys and releases produce no event; one-hot implies nonzero.
         press = is_onehot(dir_in[p]) && (dir_in[p] != key_q[p]);
         pop   = run_act && bus.i_tick && (cnt_q[p] != '0);
         // A same-cycle pop frees a slot, so a full queue still accepts.
         push  = run_act && press &&
                 (dir_in[p] != ref_dir) && (dir_in[p] != reverse_dir(ref_dir)) &&
                 ((cnt_q[p] != CW'(QDEPTH)) || pop);

         if (pop) begin
            head_d[p] = fifo_q[p][0];
            turn_d[p] = 1'b1;
            for (int i = 0; i < QDEPTH - 1; i++) begin
               fifo_d[p][i] = fifo_q[p][i + 1];
            end
         end

         wr_idx = cnt_q[p] - CW'(pop);
         if (push) begin
            for (int i = 0; i < QDEPTH; i++) begin
               if (CW'(i) == wr_idx) fifo_d[p][i] = dir_in[p];
            end
         end

         cnt_d[p] = cnt_q[p] + CW'(push) - CW'(pop);

         if (bus.i_game_over) begin
            head_d[p] = init_h[p];
            cnt_d[p]  = '0;
            turn_d[p] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      fifo_q <= fifo_d;
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         for (int p = 0; p < 2; p++) begin
            key_q[p]  <= 4'd0;
            head_q[p] <= init_h[p];
            cnt_q[p]  <= '0;
            turn_q[p] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         for (int p = 0; p < 2; p++) begin
            key_q[p]  <= key_d[p];
            head_q[p] <= head_d[p];
            cnt_q[p]  <= cnt_d[p];
            turn_q[p] <= turn_d[p];
         end
      end
   end

   assign bus.o_p1_head = head_q[0];
   assign bus.o_p2_head = head_q[1];
   assign bus.o_p1_turn = turn_q[0];
   assign bus.o_p2_turn = turn_q[1];
   assign bus.o_state   = state_q;

endmodule

// File: tb/tb_dir_scheduler.sv
module tb_dir_scheduler;

   localparam logic [3:0] U = 4'b1000;
   localparam logic [3:0] D = 4'b0100;
   localparam logic [3:0] L = 4'b0010;
   localparam logic [3:0] R = 4'b0001;
   localparam logic [3:0] Z = 4'b0000;
   localparam logic [1:0] SI = 2'b00;
   localparam logic [1:0] SR = 2'b01;
   localparam logic [1:0] SP = 2'b10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dir_scheduler_if bus ();

   dir_scheduler #(.P1_INIT(4'b0001), .P2_INIT(4'b0010), .QDEPTH(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [3:0] p1, p2;
      logic       tk, st, pa, go, rn;
      logic [3:0] h1, h2;
      logic       t1, t2;
      logic [1:0] s;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic [3:0] p1, input logic [3:0] p2,
                      input logic tk, input logic st, input logic pa,
                      input logic go, input logic rn,
                      input logic [3:0] h1, input logic [3:0] h2,
                      input logic t1, input logic t2, input logic [1:0] s);
      vec_t v;
      v.p1 = p1; v.p2 = p2; v.tk = tk; v.st = st; v.pa = pa; v.go = go; v.rn = rn;
      v.h1 = h1; v.h2 = h2; v.t1 = t1; v.t2 = t2; v.s = s;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic drv(input logic [3:0] p1, input logic [3:0] p2,
                      input logic tk, input logic st, input logic pa,
                      input logic go, input logic rn);
      bus.i_p1_dir    = p1;
      bus.i_p2_dir    = p2;
      bus.i_tick      = tk;
      bus.i_start     = st;
      bus.i_pause     = pa;
      bus.i_game_over = go;
      rst_n           = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask

   initial begin
      int seen;
      bus.i_p1_dir = '0; bus.i_p2_dir = '0; bus.i_tick = 0;
      bus.i_start = 0; bus.i_pause = 0; bus.i_game_over = 0;

      //   p1 p2 tk st pa go rn | h1 h2 t1 t2 st
      add(Z, Z, 0, 0, 0, 0, 0,  R, L, 0, 0, SI);  // reset
      add(U, Z, 1, 0, 0, 0, 1,  R, L, 0, 0, SI);  // IDLE ignores tick/press
      add(Z, Z, 1, 1, 0, 0, 1,  R, L, 0, 0, SR);  // start+tick: no pop
      add(U, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);  // press UP queued
      add(Z, Z, 1, 0, 0, 0, 1,  U, L, 1, 0, SR);  // tick commits UP
      add(Z, Z, 0, 0, 0, 0, 1,  U, L, 0, 0, SR);  // pulse one cycle only
      add(Z, Z, 0, 0, 0, 0, 0,  R, L, 0, 0, SI);  // reset
      add(Z, Z, 0, 1, 0, 0, 1,  R, L, 0, 0, SR);
      add(L, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);  // reverse rejected
      add(Z, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);
      add(R, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);  // same rejected
      add(Z, Z, 1, 0, 0, 0, 1,  R, L, 0, 0, SR);  // nothing to pop
      add(U, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);  // queue UP
      add(L, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);  // queue LEFT (full)
      add(D, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);  // DOWN dropped
      add(Z, Z, 1, 0, 0, 0, 1,  U, L, 1, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 1,  L, L, 1, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 1,  L, L, 0, 0, SR);  // empty: hold
      add(U, Z, 0, 0, 0, 0, 1,  L, L, 0, 0, SR);
      add(L, Z, 0, 0, 0, 0, 1,  L, L, 0, 0, SR);  // full: UP,LEFT
      add(D, U, 1, 0, 0, 0, 1,  U, L, 1, 0, SR);  // pop+push on full; P2 queues UP
      add(D, U, 1, 0, 0, 0, 1,  L, U, 1, 1, SR);  // held keys: no events
      add(D, Z, 1, 0, 0, 0, 1,  D, U, 1, 0, SR);
      add(D, Z, 1, 0, 0, 0, 1,  D, U, 0, 0, SR);
      add(L, Z, 0, 0, 0, 0, 1,  D, U, 0, 0, SR);  // queue LEFT
      add(L, Z, 0, 0, 1, 0, 1,  D, U, 0, 0, SP);  // pause
      add(L, Z, 1, 0, 0, 0, 1,  D, U, 0, 0, SP);  // tick ignored
      add(U, Z, 0, 0, 0, 0, 1,  D, U, 0, 0, SP);  // press ignored
      add(Z, Z, 0, 0, 1, 0, 1,  D, U, 0, 0, SR);  // resume
      add(Z, Z, 1, 0, 0, 0, 1,  L, U, 1, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 1,  L, U, 0, 0, SR);  // UP was not queued in pause
      add(4'b1100, Z, 0, 0, 0, 0, 1, L, U, 0, 0, SR); // non-one-hot ignored
      add(Z, Z, 1, 0, 0, 0, 1,  L, U, 0, 0, SR);
      add(U, R, 0, 0, 0, 0, 1,  L, U, 0, 0, SR);  // both players queue
      add(Z, Z, 1, 0, 0, 1, 1,  R, L, 0, 0, SI);  // game_over beats tick
      add(Z, Z, 1, 0, 0, 0, 1,  R, L, 0, 0, SI);
      add(Z, Z, 0, 0, 1, 0, 1,  R, L, 0, 0, SI);  // pause ignored in IDLE
      add(Z, Z, 0, 1, 0, 1, 1,  R, L, 0, 0, SI);  // game_over beats start
      add(Z, Z, 0, 1, 0, 0, 1,  R, L, 0, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 1,  R, L, 0, 0, SR);  // queues were flushed
      add(U, D, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);
      add(Z, Z, 0, 0, 1, 1, 1,  R, L, 0, 0, SI);  // game_over beats pause
      add(Z, Z, 0, 1, 0, 0, 1,  R, L, 0, 0, SR);
      add(U, Z, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 0,  R, L, 0, 0, SI);  // reset mid-RUN
      add(Z, Z, 0, 1, 0, 0, 1,  R, L, 0, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 1,  R, L, 0, 0, SR);  // nothing survived reset
      add(Z, U, 0, 0, 0, 0, 1,  R, L, 0, 0, SR);
      add(Z, U, 0, 0, 1, 0, 1,  R, L, 0, 0, SP);
      add(Z, Z, 0, 0, 0, 0, 0,  R, L, 0, 0, SI);  // reset mid-PAUSE
      add(Z, Z, 0, 1, 0, 0, 1,  R, L, 0, 0, SR);
      add(Z, Z, 1, 0, 0, 0, 1,  R, L, 0, 0, SR);

      foreach (vecs[i]) begin
         drv(vecs[i].p1, vecs[i].p2, vecs[i].tk, vecs[i].st, vecs[i].pa,
             vecs[i].go, vecs[i].rn);
         n_tests++;
         if (bus.o_p1_head !== vecs[i].h1 || bus.o_p2_head !== vecs[i].h2 ||
             bus.o_p1_turn !== vecs[i].t1 || bus.o_p2_turn !== vecs[i].t2 ||
             bus.o_state !== vecs[i].s) begin
            n_fail++;
            $display("FAIL vec%0d: got h1=%b h2=%b t1=%b t2=%b st=%b, want h1=%b h2=%b t1=%b t2=%b st=%b",
                     i, bus.o_p1_head, bus.o_p2_head, bus.o_p1_turn, bus.o_p2_turn, bus.o_state,
                     vecs[i].h1, vecs[i].h2, vecs[i].t1, vecs[i].t2, vecs[i].s);
         end
      end

      // Simultaneous presses on both players commit on the same tick.
      drv(U, D, 0, 0, 0, 0, 1);
      drv(Z, Z, 1, 0, 0, 0, 1);
      check("dual_heads", {8'h0, bus.o_p1_head, bus.o_p2_head}, {8'h0, U, D});
      check("dual_turns", {14'h0, bus.o_p1_turn, bus.o_p2_turn}, 16'h0003);
      drv(Z, Z, 0, 0, 0, 0, 1);
      check("dual_turn_width", {14'h0, bus.o_p1_turn, bus.o_p2_turn}, 16'h0000);
      drv(Z, Z, 1, 0, 0, 0, 1);
      check("empty_tick_no_turn", {14'h0, bus.o_p1_turn, bus.o_p2_turn}, 16'h0000);

      // Bounded wait for the turn pulse of a single queued press.
      drv(L, Z, 0, 0, 0, 0, 1);
      drv(Z, Z, 1, 0, 0, 0, 1);
      seen = 0;
      for (int n = 0; n < 4 && seen == 0; n++) begin
         if (bus.o_p1_turn === 1'b1) seen = 1;
         else drv(Z, Z, 0, 0, 0, 0, 1);
      end
      check("turn_seen", 16'(seen), 16'h0001);
      check("turn_head", {12'h0, bus.o_p1_head}, {12'h0, L});
      check("p2_untouched", {12'h0, bus.o_p2_head}, {12'h0, D});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
